shift_chain_serializer: RTL
===========================

# shift_chain_serializer

Controller that sequences a fixed-depth, enable-less 1-bit shift-register chain in the datapath. It accepts WIDTH-bit words over a valid/ready handshake and feeds them bit-serially, LSB first, into the head of the chain. It tracks each bit's progress through the DEPTH stages so that it can flag when chain-tail data is valid and when a word has fully emerged. It sits between a parallel producer and the serial chain; the chain itself stays a plain register pipeline outside this block.

## Interface
- WIDTH, default 8: bits per word, ≥2.
- DEPTH, default 4: number of stages in the external chain, ≥1.
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESETN  input  1  reset, asynchronous and active-low; clears all state immediately.
- in_valid  input  1  producer has a word.
- in_data  input  WIDTH  word to serialize; sampled on the accept edge.
- in_ready  output  1  block can accept a word this cycle.
- sr_i  output  1  bit driven into the head of the chain.
- busy  output  1  high in SHIFT or DRAIN.
- out_valid  output  1  chain tail currently holds a bit of an accepted word.
- out_last  output  1  that tail bit is bit WIDTH-1 of its word; 0 whenever out_valid=0.
- done  output  1  one-cycle pulse, equal to out_valid & out_last.

## Operation
- States:
  - IDLE: in_ready=1, sr_i=0.
  - SHIFT: in_ready=0, sr_i = shreg[0].
  - DRAIN: in_ready=1, sr_i=0.
- Accept occurs when in_valid & in_ready is high at a rising edge.
  - On accept: shreg ← in_data, bitcnt ← 0, state ← SHIFT.
- In SHIFT, each edge shifts shreg right by one and increments bitcnt.
  - The edge where bitcnt = WIDTH-1 moves the block to DRAIN with draincnt ← DEPTH-1.
- In DRAIN:
  - Accept moves the block to SHIFT, which overlaps the drain of the previous word.
  - Otherwise, draincnt = 0 moves the block to IDLE; else draincnt decrements.
- Tracking pipeline: a DEPTH-stage internal pipeline of {valid, last} advances on every edge.
  - Stage 0 input = {state==SHIFT, state==SHIFT && bitcnt==WIDTH-1}.
  - out_valid and out_last are the final stage.
  - The pipeline therefore matches the external chain cycle for cycle.
- Counter widths:
  - bitcnt is clog2(WIDTH) bits.
  - draincnt is clog2(DEPTH) bits, minimum 1.
  - Neither counter wraps: both are reloaded before overflow.
- Stale data: chain contents present before reset or between words are never flagged; out_valid=0 for them.
- Back-to-back words: a word accepted in DRAIN still produces the previous word's done at its correct cycle, because done comes from the pipeline and not from the state.
- in_data is ignored except on the accept edge.
- in_valid may drop at any time without an accept, with no effect.

## Timing
- Reset values:
  - State IDLE; shreg, bitcnt and draincnt = 0; tracking pipeline cleared.
  - Outputs: in_ready=1, sr_i=0, busy=0, out_valid=0, out_last=0, done=0.
  - Reset asserted mid-word aborts the word; no done is ever produced for it.
- Latencies, for an accept at edge k, with cycle k+j meaning the cycle after edge k+j-1:
  - sr_i = bit i during cycle k+1+i, for i = 0..WIDTH-1.
  - Bit i is at the chain tail, with out_valid=1, during cycle k+1+i+DEPTH.
  - done pulses in cycle k+WIDTH+DEPTH.
  - in_ready is low for exactly WIDTH cycles after an accept.
- Minimum word spacing is WIDTH+1 cycles, so sustained throughput is WIDTH/(WIDTH+1) bits per cycle.
- busy falls in cycle k+WIDTH+DEPTH+1 if no new word arrives.

## Test plan
- Single word, WIDTH=8, DEPTH=4, in_data=8'hA5, accepted at edge 0:
  - sr_i over cycles 1..8 = 1,0,1,0,0,1,0,1.
  - out_valid high for cycles 5..12; out_last and done only in cycle 12.
  - busy low from cycle 13.
- Back-to-back: 8'hFF accepted at edge 0, 8'h01 held valid from cycle 3.
  - Second accept occurs at edge 9.
  - out_valid is continuous over cycles 5..12, low in cycle 13, then high over cycles 14..21.
  - done pulses in cycle 12 and in cycle 21.
- Reset mid-word: ASYNCRESETN low in cycle 4, between edges.
  - All outputs reach their reset values immediately, with no clock edge.
  - No out_valid and no done follow.
  - A new accept after release behaves as in the single-word case.
- Producer stall: in_valid low for 20 cycles while idle.
  - in_ready stays 1, sr_i stays 0, no outputs toggle.
  - Changing in_data during the stall has no effect.
- Parameter corners: WIDTH=2, DEPTH=1, in_data=2'b10.
  - sr_i = 0 then 1.
  - done pulses in cycle 3.
  - DRAIN lasts exactly 1 cycle.

Source files
------------

// File: rtl/shift_chain_serializer.sv
// Purpose: serializes WIDTH-bit words LSB first into an external DEPTH-stage shift chain and flags valid/last data at the chain tail.
// Latency: bit i is on sr_i in cycle k+1+i after accept edge k, at the tail in cycle k+1+i+DEPTH, and done pulses in cycle k+WIDTH+DEPTH.
// Backpressure: in_ready is low only while shifting (WIDTH cycles); a new word may be accepted while the previous one drains.
module shift_chain_serializer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             sr_i,
   output logic             busy,
   output logic             out_valid,
   output logic             out_last,
   output logic             done
);
   localparam int BW = $clog2(WIDTH);
   localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [BW-1:0]    bitcnt, bitcnt_nxt;
   logic [DW-1:0]    draincnt, draincnt_nxt;
   logic             accept;

   // {valid,last} shadow of the external chain; advances every edge like the chain itself
   logic [DEPTH-1:0] trk_vld;
   logic [DEPTH-1:0] trk_last;

   // Next-state and output decode; counters hold instead of wrapping at their end values
   always_comb begin
      state_nxt    = state;
      shreg_nxt    = shreg;
      bitcnt_nxt   = bitcnt;
      draincnt_nxt = draincnt;
      in_ready     = (state != SHIFT);
      sr_i         = (state == SHIFT) ? shreg[0] : 1'b0;
      busy         = (state != IDLE);
      accept       = in_valid & (state != SHIFT);

      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt  = SHIFT;
               shreg_nxt  = in_data;
               bitcnt_nxt = '0;
            end
         end
         SHIFT: begin
            shreg_nxt = shreg >> 1;
            if (bitcnt == BIT_LAST) begin
               state_nxt    = DRAIN;
               draincnt_nxt = DRAIN_LOAD;
            end else begin
               bitcnt_nxt = bitcnt + 1'b1;
            end
         end
         DRAIN: begin
            // A new word starts shifting while the old one is still moving down the chain
            if (accept) begin
               state_nxt  = SHIFT;
               shreg_nxt  = in_data;
               bitcnt_nxt = '0;
            end else if (draincnt == '0) begin
               state_nxt = IDLE;
            end else begin
               draincnt_nxt = draincnt - 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Control state register
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state    <= IDLE;
         shreg    <= '0;
         bitcnt   <= '0;
         draincnt <= '0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         bitcnt   <= bitcnt_nxt;
         draincnt <= draincnt_nxt;
      end
   end

   // Tracking pipeline: tags each bit entering the chain so the tail flags line up cycle for cycle
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         trk_vld  <= '0;
         trk_last <= '0;
      end else begin
         trk_vld[0]  <= (state == SHIFT);
         trk_last[0] <= (state == SHIFT) && (bitcnt == BIT_LAST);
         for (int i = 1; i < DEPTH; i++) begin
            trk_vld[i]  <= trk_vld[i-1];
            trk_last[i] <= trk_last[i-1];
         end
      end
   end

   // Tail flags; last is only ever set alongside valid, so done needs no extra state
   always_comb begin
      out_valid = trk_vld[DEPTH-1];
      out_last  = trk_last[DEPTH-1];
      done      = trk_vld[DEPTH-1] & trk_last[DEPTH-1];
   end

endmodule
